// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: drains a contiguous register range through the r1 read port
// and streams each value on a valid/ready interface. Rev 1.0
`default_nettype none

module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_r1,
  output logic [ADDR_W-1:0] rf_r2,
  output logic              rf_r_en,
  input  logic [DATA_W-1:0] rf_r1_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_index,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   end_q;
  logic [DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]   index_q;
  logic                last_q;
  logic                done_q;
  logic                err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              if (first_reg <= last_reg) begin
                addr_q  <= first_reg;
                end_q   <= last_reg;
                state_q <= ISSUE;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ISSUE: begin
            state_q <= CAPTURE;
          end
          CAPTURE: begin
            data_q  <= rf_r1_data;
            index_q <= addr_q;
            last_q  <= (addr_q == end_q);
            state_q <= PRESENT;
          end
          PRESENT: begin
            // The end compare stops the dump before addr can wrap past the top register.
            if (dout_ready) begin
              if (last_q) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                addr_q  <= ADDR_W'(addr_q + 1'b1);
                state_q <= ISSUE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rf_r1      = (state_q != IDLE) ? addr_q : '0;
  assign rf_r2      = '0;
  assign rf_r_en    = (state_q == ISSUE);
  assign dout_valid = (state_q == PRESENT);
  assign dout_data  = data_q;
  assign dout_index = index_q;
  assign dout_last  = last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed bench for regfile_dump_reader with a small
// register-file model behind the r1 port.
`default_nettype none

module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rf_r1;
  logic [4:0]  rf_r2;
  logic        rf_r_en;
  logic [31:0] rf_r1_data = 32'd0;
  logic        dout_valid;
  logic        dout_ready;
  logic [31:0] dout_data;
  logic [4:0]  dout_index;
  logic        dout_last;
  logic        busy;
  logic        done;
  logic        err;

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_r_en(rf_r_en), .rf_r1_data(rf_r1_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_index(dout_index), .dout_last(dout_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file model: registered read, x0 hardwired to zero.
  logic [31:0] regs [32];
  always @(posedge clk) if (rf_r_en) rf_r1_data <= (rf_r1 == 5'd0) ? 32'd0 : regs[rf_r1];

  function automatic logic [31:0] expv(input int i);
    return (i == 0) ? 32'd0 : regs[i];
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int          w_idx  [$];
  logic [31:0] w_data [$];
  bit          w_last [$];
  int          w_vcyc [$];
  int          n_en, done_cyc, order_bad, stable_bad, abort_done_seen;

  // Starts a dump and follows it cycle by cycle, sampling at the falling edge.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit rnd,
                          input int abort_idx, input bit busy_start, input int budget);
    int vstart, exp_addr;
    bit pv, pr;
    logic [31:0] pd;
    logic [4:0]  pi;
    bit          pl;
    w_idx.delete(); w_data.delete(); w_last.delete(); w_vcyc.delete();
    n_en = 0; done_cyc = -1; order_bad = 0; stable_bad = 0; abort_done_seen = 0;
    exp_addr = int'(f); pv = 0; pr = 0; vstart = 0; pd = '0; pi = '0; pl = 0;
    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l; dout_ready = 1'b0;
    @(negedge clk);
    if (busy_start) begin first_reg = 5'd0; last_reg = 5'd31; end
    else start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        start = 1'b0;
        done_cyc = c;
        chk("done_busy", busy, 0);
        break;
      end
      if (rf_r_en) begin
        n_en++;
        if (rf_r1 !== exp_addr[4:0]) order_bad++;
        exp_addr++;
      end
      if (dout_valid) begin
        if (!pv) vstart = c;
        else if (!pr && (dout_data !== pd || dout_index !== pi || dout_last !== pl)) stable_bad++;
        pd = dout_data; pi = dout_index; pl = dout_last;
        if (abort_idx >= 0 && int'(dout_index) == abort_idx) begin
          abort = 1'b1; dout_ready = 1'b0;
        end else begin
          dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (dout_ready) begin
          w_idx.push_back(int'(dout_index)); w_data.push_back(dout_data);
          w_last.push_back(dout_last); w_vcyc.push_back(vstart);
        end
      end else begin
        dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      pv = dout_valid; pr = dout_ready;
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", dout_valid, 0);
        for (int k = 0; k < 4; k++) begin
          if (done) abort_done_seen++;
          @(negedge clk);
        end
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i * 32'h111);
    regs[1] = 32'h0; regs[2] = 32'h8000_0FFC; regs[3] = 32'h0;

    rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
    first_reg = '0; last_reg = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ren", rf_r_en, 0);
    chk("rst_r1", rf_r1, 0);
    chk("rst_r2", rf_r2, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_done_err", {done, err}, 0);
    rst = 1'b0;

    // Dump 0..3 at full rate.
    run_dump(5'd0, 5'd3, 0, -1, 0, 40);
    chk("t1_nwords", w_idx.size(), 4);
    for (int i = 0; i < w_idx.size(); i++) begin
      chk($sformatf("t1_idx%0d", i), w_idx[i], i);
      chk($sformatf("t1_data%0d", i), w_data[i], expv(i));
      chk($sformatf("t1_last%0d", i), w_last[i], (i == 3));
      chk($sformatf("t1_vcyc%0d", i), w_vcyc[i], 3 + 3 * i);
    end
    chk("t1_data2_abs", w_data.size() > 2 ? w_data[2] : 32'd0, 32'h8000_0FFC);
    chk("t1_done_cyc", done_cyc, 13);
    chk("t1_n_en", n_en, 4);
    chk("t1_addr_order", order_bad, 0);

    // Single-register dump.
    regs[5] = 32'hDEAD_BEEF;
    run_dump(5'd5, 5'd5, 0, -1, 0, 40);
    chk("t2_nwords", w_idx.size(), 1);
    chk("t2_idx", w_idx.size() > 0 ? w_idx[0] : -1, 5);
    chk("t2_data", w_data.size() > 0 ? w_data[0] : 32'd0, 32'hDEAD_BEEF);
    chk("t2_last", w_last.size() > 0 ? w_last[0] : 1'b0, 1);
    chk("t2_done_cyc", done_cyc, 4);
    chk("t2_n_en", n_en, 1);

    // Full range with random backpressure.
    run_dump(5'd0, 5'd31, 1, -1, 0, 600);
    chk("t3_nwords", w_idx.size(), 32);
    begin
      int bad_idx, bad_data, bad_last;
      bad_idx = 0; bad_data = 0; bad_last = 0;
      for (int i = 0; i < w_idx.size(); i++) begin
        if (w_idx[i] != i) bad_idx++;
        if (w_data[i] !== expv(i)) bad_data++;
        if (w_last[i] != (i == 31)) bad_last++;
      end
      chk("t3_idx_order", bad_idx, 0);
      chk("t3_data", bad_data, 0);
      chk("t3_last", bad_last, 0);
    end
    chk("t3_stable", stable_bad, 0);
    chk("t3_n_en", n_en, 32);
    chk("t3_addr_order", order_bad, 0);
    chk("t3_done_seen", done_cyc > 0, 1);

    // Rejected range.
    @(negedge clk);
    start = 1'b1; first_reg = 5'd7; last_reg = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ren", rf_r_en, 0);
    chk("t4_done", done, 0);
    @(negedge clk);
    chk("t4_err_pulse", err, 0);
    chk("t4_valid", dout_valid, 0);
    chk("t4_busy2", busy, 0);

    // Abort while presenting index 10, then a fresh short dump.
    run_dump(5'd0, 5'd31, 0, 10, 0, 100);
    chk("t5_nwords", w_idx.size(), 10);
    chk("t5_no_done", abort_done_seen, 0);
    run_dump(5'd0, 5'd1, 0, -1, 0, 40);
    chk("t5b_nwords", w_idx.size(), 2);
    chk("t5b_last_idx", w_idx.size() > 1 ? w_idx[1] : -1, 1);
    chk("t5b_done_cyc", done_cyc, 7);

    // Start while busy is ignored; reset in CAPTURE clears everything.
    @(negedge clk);
    start = 1'b1; first_reg = 5'd4; last_reg = 5'd5;
    @(negedge clk);
    first_reg = 5'd0; last_reg = 5'd31;
    chk("t6_issue_r1", rf_r1, 4);
    chk("t6_issue_ren", rf_r_en, 1);
    @(negedge clk);
    chk("t6_capture_r1", rf_r1, 4);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_r1", rf_r1, 0);
    chk("t6_rst_ren", rf_r_en, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_data", dout_data, 0);
    chk("t6_rst_index_last", {dout_index, dout_last}, 0);
    chk("t6_rst_busy_done_err", {busy, done, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_after_rst", busy, 0);

    run_dump(5'd8, 5'd9, 0, -1, 1, 40);
    chk("t7_nwords", w_idx.size(), 2);
    chk("t7_first_idx", w_idx.size() > 0 ? w_idx[0] : -1, 8);
    chk("t7_done_cyc", done_cyc, 7);
    @(negedge clk);
    chk("t7_no_restart", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
